// File: rtl/rx_sched_pkg.sv
// Shared types and constants for the Rx packet scheduler: FSM states,
// header geometry and datapath widths.
package rx_sched_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HDR     = 2'd1,
        PAYLOAD = 2'd2,
        GAP     = 2'd3
    } sched_state_t;

    localparam int HDR_LEN_BASE = 5;
    localparam int TS_BYTES     = 4;
    localparam int SEQ_W        = 32;
    localparam int CNT_W        = 11;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin selector: picks the first requester after 'last',
// wrapping modulo NR.
module rr_arbiter #(
    parameter int NR = 4
) (
    input  logic [NR-1:0] req,
    input  logic [2:0]    last,
    output logic [2:0]    gnt_idx,
    output logic          any
);

    // Each requester's distance from the slot after 'last'; the nearest wins.
    always_comb begin
        int best;
        int d;
        best    = NR;
        d       = 0;
        gnt_idx = last;
        for (int i = 0; i < NR; i++) begin
            d = (i - int'(last) - 1 + 8 * NR) % NR;
            if (req[i] && d < best) begin
                best    = d;
                gnt_idx = 3'(i);
            end
        end
        any = |req;
    end

endmodule

// File: rtl/rx_packet_scheduler.sv
// Round-robin packet scheduler from NR Rx byte FIFOs to one byte stream.
// Optional RX_SCHED_TIMESTAMP_EN appends a 32-bit cycle timestamp to the header.
module rx_packet_scheduler
    import rx_sched_pkg::*;
#(
    parameter int NR        = 4,
    parameter int PKT_BYTES = 1428
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [NR-1:0]     rx_enable,
    input  logic [NR-1:0]     rx_ready,
    input  logic [8*NR-1:0]   rd_data,
    output logic [NR-1:0]     rd_req,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    output logic              tx_sop,
    output logic              tx_eop,
    input  logic              tx_ready,
    output logic              busy,
    output logic [2:0]        grant
);

`ifdef RX_SCHED_TIMESTAMP_EN
    localparam int HDR_LEN = HDR_LEN_BASE + TS_BYTES;
`else
    localparam int HDR_LEN = HDR_LEN_BASE;
`endif
    localparam int IDX_W = (NR > 1) ? $clog2(NR) : 1;

    sched_state_t         state_q, state_d;
    logic [CNT_W-1:0]     cnt_q;
    logic [2:0]           grant_q;
    logic [SEQ_W-1:0]     seq_q [NR];
    logic [NR-1:0]        en_q;
    logic [NR-1:0]        en_rise;
    logic [2:0]           arb_idx;
    logic                 arb_any;
    logic [IDX_W-1:0]     gidx;
    logic [SEQ_W-1:0]     seq_cur;
    logic                 hdr_last, pay_last, seq_inc;
    logic [7:0]           hdr_byte;

    rr_arbiter #(.NR(NR)) u_arb (
        .req     (rx_ready & rx_enable),
        .last    (grant_q),
        .gnt_idx (arb_idx),
        .any     (arb_any)
    );

    assign gidx     = grant_q[IDX_W-1:0];
    assign seq_cur  = seq_q[gidx];
    assign hdr_last = (cnt_q == CNT_W'(HDR_LEN - 1));
    assign pay_last = (cnt_q == CNT_W'(PKT_BYTES - 1));
    assign seq_inc  = (state_q == PAYLOAD) && tx_ready && pay_last;
    assign en_rise  = rx_enable & ~en_q;
    assign grant    = grant_q;

    always_ff @(posedge clock) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (arb_any) state_d = HDR;
            HDR:     if (tx_ready && hdr_last) state_d = PAYLOAD;
            PAYLOAD: if (tx_ready && pay_last) state_d = GAP;
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q   <= '0;
            grant_q <= 3'(NR - 1);
            en_q    <= '0;
        end else begin
            en_q <= rx_enable;
            unique case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    if (arb_any) grant_q <= arb_idx;
                end
                HDR:     if (tx_ready) cnt_q <= hdr_last ? '0 : cnt_q + 1'b1;
                PAYLOAD: if (tx_ready) cnt_q <= cnt_q + 1'b1;
                default: cnt_q <= '0;
            endcase
        end
    end

    // A fresh enable restarts that receiver's numbering, even over an eop increment.
    always_ff @(posedge clock) begin
        for (int i = 0; i < NR; i++) begin
            if (reset || en_rise[i])
                seq_q[i] <= '0;
            else if (seq_inc && gidx == IDX_W'(i))
                seq_q[i] <= seq_q[i] + 1'b1;
        end
    end

`ifdef RX_SCHED_TIMESTAMP_EN
    logic [SEQ_W-1:0] ts_cnt_q, ts_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            ts_cnt_q <= '0;
            ts_q     <= '0;
        end else begin
            ts_cnt_q <= ts_cnt_q + 1'b1;
            if (state_q == IDLE && arb_any) ts_q <= ts_cnt_q;
        end
    end
`endif

    always_comb begin
        hdr_byte = '0;
        case (cnt_q)
            11'd0:   hdr_byte = {5'b0, grant_q};
            11'd1:   hdr_byte = seq_cur[31:24];
            11'd2:   hdr_byte = seq_cur[23:16];
            11'd3:   hdr_byte = seq_cur[15:8];
            11'd4:   hdr_byte = seq_cur[7:0];
`ifdef RX_SCHED_TIMESTAMP_EN
            11'd5:   hdr_byte = ts_q[31:24];
            11'd6:   hdr_byte = ts_q[23:16];
            11'd7:   hdr_byte = ts_q[15:8];
            11'd8:   hdr_byte = ts_q[7:0];
`endif
            default: hdr_byte = '0;
        endcase
    end

    // rd_req follows tx_ready so a FIFO byte is only popped when it is accepted.
    always_comb begin
        tx_data  = '0;
        tx_valid = 1'b0;
        tx_sop   = 1'b0;
        tx_eop   = 1'b0;
        rd_req   = '0;
        busy     = 1'b0;
        unique case (state_q)
            HDR: begin
                tx_valid = 1'b1;
                tx_sop   = (cnt_q == '0);
                tx_data  = hdr_byte;
                busy     = 1'b1;
            end
            PAYLOAD: begin
                tx_valid     = 1'b1;
                tx_data      = rd_data[{gidx, 3'b000} +: 8];
                tx_eop       = pay_last;
                rd_req[gidx] = tx_ready;
                busy         = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
